// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for a single-port data RAM: one grant cycle, then one response cycle.
// Define DRAM_ARB_RR_EN for round-robin arbitration; default build gives m0 fixed priority.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_stall,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, RESP} state_t;

  state_t state, state_nxt;
  logic   gnt1, gnt1_nxt;   // master owning the pending response
  logic   pick1;            // arbitration result when any request is present

`ifdef DRAM_ARB_RR_EN
  logic last_gnt;

  assign pick1 = (m0_req && m1_req) ? ~last_gnt : m1_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 last_gnt <= 1'b1;
    else if (state == IDLE && (m0_req || m1_req)) last_gnt <= pick1;
  end
`else
  assign pick1 = ~m0_req & m1_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt1  <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt1  <= gnt1_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt1_nxt  = gnt1;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) state_nxt = pick1 ? GNT1 : GNT0;
      end
      GNT0: begin
        state_nxt = RESP;
        gnt1_nxt  = 1'b0;
        ram_ce    = 1'b1;
        ram_we    = m0_we;
        ram_addr  = m0_addr;
        ram_sel   = m0_sel;
        ram_wdata = m0_we ? m0_wdata : '0;
      end
      GNT1: begin
        state_nxt = RESP;
        gnt1_nxt  = 1'b1;
        ram_ce    = 1'b1;
        ram_we    = m1_we;
        ram_addr  = m1_addr;
        ram_sel   = m1_sel;
        ram_wdata = m1_we ? m1_wdata : '0;
      end
      RESP: begin
        state_nxt = IDLE;
        m0_ack    = ~gnt1;
        m1_ack    = gnt1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data captured at the end of the grant cycle; writes return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (state == GNT0) m0_rdata <= m0_we ? '0 : ram_rdata;
      if (state == GNT1) m1_rdata <= m1_we ? '0 : ram_rdata;
    end
  end

  assign m0_stall = m0_req & ~m0_ack;
  assign m1_stall = m1_req & ~m1_ack;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: cycle-by-cycle vector table plus multi-cycle sequences.
module tb_data_ram_arbiter;

  typedef struct packed {
    logic r0; logic w0; logic [31:0] a0; logic [3:0] s0; logic [31:0] d0;
    logic r1; logic w1; logic [31:0] a1; logic [3:0] s1; logic [31:0] d1;
  } stim_t;

  typedef struct packed {
    logic ce; logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata;
    logic ack0; logic ack1; logic st0; logic st1; logic [31:0] rd0; logic [31:0] rd1;
  } out_t;

  typedef struct { stim_t s; out_t e; } vec_t;

  localparam logic [31:0] V10 = 32'hDEADBEEF;
  localparam logic [31:0] V20 = 32'hCAFEBABE;
  localparam logic [31:0] V40 = 32'hAAAAAAAA;

  logic        clk, rst;
  logic        m0_req, m0_we, m0_ack, m0_stall;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_sel;
  logic        m1_req, m1_we, m1_ack, m1_stall;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_sel;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  logic        ram_load;
  logic [31:0] mem [64];
  logic [5:0]  wi;

  int n_chk, n_pass;
  vec_t tv[$];

  data_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_stall(m1_stall),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word RAM: combinational read, byte-lane write on the rising edge.
  assign wi        = 6'(ram_addr >> 2);
  assign ram_rdata = mem[wi];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[4]  <= V10;
      mem[8]  <= V20;
      mem[16] <= V40;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[wi][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  function automatic stim_t m0s(input logic r, input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d);
    stim_t x;
    x = '0;
    x.r0 = r; x.w0 = w; x.a0 = a; x.s0 = s; x.d0 = d;
    return x;
  endfunction

  function automatic stim_t m1s(input logic r, input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d);
    stim_t x;
    x = '0;
    x.r1 = r; x.w1 = w; x.a1 = a; x.s1 = s; x.d1 = d;
    return x;
  endfunction

  function automatic out_t ex(input logic ce, input logic we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] wd,
                              input logic a0, input logic a1, input logic s0, input logic s1,
                              input logic [31:0] r0, input logic [31:0] r1);
    out_t o;
    o.ce = ce; o.we = we; o.addr = addr; o.sel = sel; o.wdata = wd;
    o.ack0 = a0; o.ack1 = a1; o.st0 = s0; o.st1 = s1; o.rd0 = r0; o.rd1 = r1;
    return o;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.ce = ram_ce; o.we = ram_we; o.addr = ram_addr; o.sel = ram_sel; o.wdata = ram_wdata;
    o.ack0 = m0_ack; o.ack1 = m1_ack; o.st0 = m0_stall; o.st1 = m1_stall;
    o.rd0 = m0_rdata; o.rd1 = m1_rdata;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    m0_req = s.r0; m0_we = s.w0; m0_addr = s.a0; m0_sel = s.s0; m0_wdata = s.d0;
    m1_req = s.r1; m1_we = s.w1; m1_addr = s.a1; m1_sel = s.s1; m1_wdata = s.d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input stim_t s, input out_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    tv.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stim_t none, r0_10, w1_20, r1_20, w1b_20, r0_20, d0_20;
    int got, saw, exp_g;

    n_chk = 0;
    n_pass = 0;
    none   = '0;
    r0_10  = m0s(1'b1, 1'b0, 32'h10, 4'hF, 32'hFFFFFFFF);
    w1_20  = m1s(1'b1, 1'b1, 32'h20, 4'b0011, 32'h12345678);
    r1_20  = m1s(1'b1, 1'b0, 32'h20, 4'hF, 32'hFFFFFFFF);
    w1b_20 = m1s(1'b1, 1'b1, 32'h20, 4'b1100, 32'hA5A50000);
    r0_20  = m0s(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    d0_20  = m0s(1'b0, 1'b0, 32'h20, 4'hF, 32'h0);

    // One entry per clock cycle; expected values reflect the state reached in that cycle.
    add(none,   ex(0, 0, 0,     0,       0,            0, 0, 0, 0, 0,            0));
    add(r0_10,  ex(0, 0, 0,     0,       0,            0, 0, 1, 0, 0,            0));
    add(r0_10,  ex(1, 0, 32'h10, 4'hF,   0,            0, 0, 1, 0, 0,            0));
    add(r0_10,  ex(0, 0, 0,     0,       0,            1, 0, 0, 0, V10,          0));
    add(none,   ex(0, 0, 0,     0,       0,            0, 0, 0, 0, V10,          0));
    add(w1_20,  ex(0, 0, 0,     0,       0,            0, 0, 0, 1, V10,          0));
    add(w1_20,  ex(1, 1, 32'h20, 4'b0011, 32'h12345678, 0, 0, 0, 1, V10,         0));
    add(w1_20,  ex(0, 0, 0,     0,       0,            0, 1, 0, 0, V10,          0));
    add(r1_20,  ex(0, 0, 0,     0,       0,            0, 0, 0, 1, V10,          0));
    add(r1_20,  ex(1, 0, 32'h20, 4'hF,   0,            0, 0, 0, 1, V10,          0));
    add(r1_20,  ex(0, 0, 0,     0,       0,            0, 1, 0, 0, V10,          32'hCAFE5678));
    add(w1b_20, ex(0, 0, 0,     0,       0,            0, 0, 0, 1, V10,          32'hCAFE5678));
    add(w1b_20, ex(1, 1, 32'h20, 4'b1100, 32'hA5A50000, 0, 0, 0, 1, V10,         32'hCAFE5678));
    add(w1b_20, ex(0, 0, 0,     0,       0,            0, 1, 0, 0, V10,          0));
    add(r0_20,  ex(0, 0, 0,     0,       0,            0, 0, 1, 0, V10,          0));
    add(d0_20,  ex(1, 0, 32'h20, 4'hF,   0,            0, 0, 0, 0, V10,          0));
    add(d0_20,  ex(0, 0, 0,     0,       0,            1, 0, 0, 0, 32'hA5A55678, 0));
    add(none,   ex(0, 0, 0,     0,       0,            0, 0, 0, 0, 32'hA5A55678, 0));

    rst = 1'b0;
    ram_load = 1'b1;
    apply(none);
    step();
    ram_load = 1'b0;
    chk("reset_state", 192'(get_out()), 192'(ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    step();
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i].s);
      #1;
      chk($sformatf("vec%0d", i), 192'(get_out()), 192'(tv[i].e));
      step();
    end

    // Reset with non-zero read data held.
    apply(none);
    rst = 1'b0;
    #1;
    chk("reset_clears", 192'(get_out()), 192'(ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    step();
    rst = 1'b1;

    // Both masters hold requests across four transactions.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_sel = 4'hF; m1_wdata = '0;
    for (int t = 0; t < 4; t++) begin
      got = -1;
      for (int c = 0; c < 6 && got < 0; c++) begin
        step();
        if (m0_ack && m1_ack) got = 2;
        else if (m0_ack)      got = 0;
        else if (m1_ack)      got = 1;
      end
`ifdef DRAM_ARB_RR_EN
      exp_g = t % 2;
`else
      exp_g = 0;
`endif
      chk($sformatf("grant%0d", t), 192'(got), 192'(exp_g));
    end
    apply(none);
    step();
    step();

    // Reset pulse in the middle of an m1 write grant.
    apply(m1s(1'b1, 1'b1, 32'h40, 4'hF, 32'h55555555));
    step();
    chk("abort_gnt", 192'({ram_ce, ram_we, ram_addr}), 192'({1'b1, 1'b1, 32'h40}));
    #2;
    rst = 1'b0;
    #1;
    chk("abort_outs",
        192'({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata}),
        192'(0));
    step();
    apply(none);
    rst = 1'b1;
    chk("abort_mem", 192'(mem[16]), 192'(V40));
    saw = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (m1_ack || m0_ack || ram_ce) saw = 1;
    end
    chk("abort_quiet", 192'(saw), 192'(0));

    // First request after reset release follows normal latency.
    apply(m0s(1'b1, 1'b0, 32'h40, 4'hF, 32'h0));
    #1;
    chk("post_rst_idle", 192'({ram_ce, m0_ack, m0_stall}), 192'({1'b0, 1'b0, 1'b1}));
    step();
    chk("post_rst_gnt", 192'({ram_ce, ram_we, ram_addr}), 192'({1'b1, 1'b0, 32'h40}));
    step();
    chk("post_rst_ack", 192'({m0_ack, m0_rdata}), 192'({1'b1, V40}));
    apply(none);
    step();

    // m1 request arriving during m0 response waits for the next IDLE evaluation.
    apply(r0_10);
    step();
    step();
    apply(stim_t'(r0_10 | m1s(1'b1, 1'b0, 32'h20, 4'hF, 32'h0)));
    #1;
    chk("late_m0_ack", 192'({m0_ack, m1_ack, m0_rdata}), 192'({1'b1, 1'b0, V10}));
    step();
    apply(m1s(1'b1, 1'b0, 32'h20, 4'hF, 32'h0));
    #1;
    chk("late_idle", 192'({m0_ack, m1_ack, ram_ce}), 192'(0));
    step();
    chk("late_gnt1", 192'({ram_ce, ram_addr, m0_ack, m1_ack}), 192'({1'b1, 32'h20, 1'b0, 1'b0}));
    step();
    chk("late_m1_ack", 192'({m1_ack, m0_ack, m1_rdata}), 192'({1'b1, 1'b0, 32'hA5A55678}));
    apply(none);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
